// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs a req/ready handshake to
// instruction memory, and applies beq/j redirects while the core is in ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [2:0]  ST_IF       = 3'd0,
    parameter logic [2:0]  ST_ID       = 3'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        branch_flag,
    input  logic        jump_flag,
    input  logic        zero,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        fetch_done,
    output logic        fetch_err
);

    localparam int          CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DONE = 2'd2,
        F_ERR  = 2'd3
    } fstate_t;

    fstate_t          fsm_reg, fsm_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      ir_reg, ir_next;
    logic [31:0]      addr_reg, addr_next;
    logic             req_reg, req_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic             launch;
    logic             in_id;
    logic [31:0]      jump_target;
    logic [31:0]      branch_target;

    assign launch        = (fsm_reg == F_IDLE) && (state == ST_IF) && !err_reg;
    // Redirects only apply once the fetch has settled; F_ERR freezes the PC.
    assign in_id         = (state == ST_ID) && ((fsm_reg == F_IDLE) || (fsm_reg == F_DONE));
    assign jump_target   = {pc_reg[31:28], ir_reg[25:0], 2'b00};
    assign branch_target = pc_reg + {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg <= F_IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            F_IDLE: begin
                if (launch) begin
                    fsm_next = F_WAIT;
                end
            end
            F_WAIT: begin
                if (imem_ready) begin
                    fsm_next = F_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    fsm_next = F_ERR;
                end
            end
            F_DONE: begin
                if (state != ST_IF) begin
                    fsm_next = F_IDLE;
                end
            end
            default: fsm_next = F_ERR;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_next  = cnt_reg;
        pc_next   = pc_reg;
        ir_next   = ir_reg;
        addr_next = addr_reg;
        req_next  = req_reg;
        done_next = 1'b0;
        err_next  = err_reg;
        case (fsm_reg)
            F_IDLE: begin
                if (launch) begin
                    req_next  = 1'b1;
                    addr_next = pc_reg;
                    cnt_next  = '0;
                end
            end
            F_WAIT: begin
                if (imem_ready) begin
                    ir_next   = imem_rdata;
                    pc_next   = pc_reg + 32'd4;
                    req_next  = 1'b0;
                    done_next = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    req_next = 1'b0;
                    err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (in_id) begin
            if (jump_flag) begin
                pc_next = jump_target;
            end else if (branch_flag && zero) begin
                pc_next = branch_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            pc_reg   <= PC_INIT;
            ir_reg   <= 32'h0;
            addr_reg <= 32'h0;
            req_reg  <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            pc_reg   <= pc_next;
            ir_reg   <= ir_next;
            addr_reg <= addr_next;
            req_reg  <= req_next;
            done_reg <= done_next;
            err_reg  <= err_next;
        end
    end

    assign imem_req   = req_reg;
    assign imem_addr  = addr_reg;
    assign pc         = pc_reg;
    assign ir         = ir_reg;
    assign fetch_done = done_reg;
    assign fetch_err  = err_reg;

endmodule
